mux8x1_scanner: RTL and testbench

Sequencer that sits directly upstream of an 8:1 mux. It drives the mux select lines through all eight channels, samples the single-bit mux output after a programmable settle time, and assembles the eight samples into a parallel byte. The byte is offered downstream on a valid/ready handshake. In the system, `s` connects to the mux select and `y` to the mux output, so the block turns any 8-bit source behind the mux into a scanned byte stream.

---
 rtl/mux8x1_scanner.sv | 117 +++++++++++
 tb/tb_mux8x1_scanner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8x1_scanner.sv
// Scans an external 8:1 mux: steps the select through channels 0..7, samples the
// mux output after a settle delay and offers the assembled byte on valid/ready.
module mux8x1_scanner #(
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       y,
  output logic [2:0] s,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  // state  | meaning
  // IDLE   | waiting for start
  // SETTLE | select driven, counting down the settle window
  // SAMPLE | capture y into asm[s], advance select
  // DONE   | word presented, waiting for handshake
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int          RELOAD_I = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam logic [3:0]  RELOAD   = RELOAD_I[3:0];
  // With no settle time the select window is the SAMPLE cycle itself.
  localparam state_t      FIRST    = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  s_q, s_d;
  logic [7:0]  asm_q, asm_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      s_q     <= 3'd0;
      asm_q   <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    asm_d   = asm_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          s_d     = 3'd0;
          asm_d   = 8'h00;
          cnt_d   = RELOAD;
          state_d = FIRST;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        asm_d[s_q] = y;
        if (s_q != 3'd7) begin
          s_d     = s_q + 3'd1;
          cnt_d   = RELOAD;
          state_d = FIRST;
        end else begin
          data_d  = {y, asm_q[6:0]};
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          if (cont) begin
            s_d     = 3'd0;
            asm_d   = 8'h00;
            cnt_d   = RELOAD;
            state_d = FIRST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s     = s_q;
  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mux8x1_scanner.sv
// Directed bench: two scanner instances (settle 1 and settle 0), each closed
// through a behavioural 8:1 mux whose input word is driven by the bench.
module tb_mux8x1_scanner;

  logic       clk;
  logic       rst_n;

  logic       start1, cont1, ready1, busy1, valid1, y1;
  logic [2:0] s1;
  logic [7:0] data1, in1;

  logic       start0, cont0, ready0, busy0, valid0, y0;
  logic [2:0] s0;
  logic [7:0] data0, in0;

  int total;
  int bad;

  assign y1 = in1[s1];
  assign y0 = in0[s0];

  mux8x1_scanner #(.SETTLE_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1), .y(y1),
    .s(s1), .data(data1), .valid(valid1), .ready(ready1), .busy(busy1)
  );

  mux8x1_scanner #(.SETTLE_CYC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cont(cont0), .y(y0),
    .s(s0), .data(data0), .valid(valid0), .ready(ready0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++;
      if (s1 !== 3'd0 || data1 !== 8'h00 || valid1 !== 1'b0 || busy1 !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle1 cyc=%0d got s=%0d data=%h valid=%b busy=%b want 0/00/0/0",
                 k, s1, data1, valid1, busy1);
      end
      total++;
      if (s0 !== 3'd0 || data0 !== 8'h00 || valid0 !== 1'b0 || busy0 !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle0 cyc=%0d got s=%0d data=%h valid=%b busy=%b want 0/00/0/0",
                 k, s0, data0, valid0, busy0);
      end
    end
  endtask

  task automatic test_single_scan();
    logic [2:0] exp_s;
    in1 = 8'hA5; ready1 = 1'b1; cont1 = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    total++;
    if (busy1 !== 1'b1 || s1 !== 3'd0) begin
      bad++;
      $display("FAIL scan_start got busy=%b s=%0d want 1/0", busy1, s1);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_s = (k < 16) ? 3'(k / 2) : 3'd7;
      total++;
      if (s1 !== exp_s || valid1 !== (k == 16)) begin
        bad++;
        $display("FAIL scan_step k=%0d got s=%0d valid=%b want s=%0d valid=%b",
                 k, s1, valid1, exp_s, (k == 16));
      end
    end
    total++;
    if (data1 !== 8'hA5) begin
      bad++;
      $display("FAIL scan_data got %h want a5", data1);
    end
    @(negedge clk);
    total++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0 || data1 !== 8'hA5) begin
      bad++;
      $display("FAIL scan_handshake got valid=%b busy=%b data=%h want 0/0/a5",
               valid1, busy1, data1);
    end
  endtask

  task automatic test_walking();
    int lat;
    logic [7:0] w;
    ready1 = 1'b1; cont1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w = 8'h01 << i;
      in1 = w;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (valid1) begin lat = n; break; end
      end
      total++;
      if (lat != 16 || data1 !== w) begin
        bad++;
        $display("FAIL walk i=%0d got lat=%0d data=%h want lat=16 data=%h", i, lat, data1, w);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    in1 = 8'h3C; ready1 = 1'b0; cont1 = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (valid1) begin lat = n; break; end
    end
    total++;
    if (lat != 16) begin
      bad++;
      $display("FAIL bp_latency got %0d want 16", lat);
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 4) in1 = 8'hFF;
      @(negedge clk);
      total++;
      if (valid1 !== 1'b1 || data1 !== 8'h3C || s1 !== 3'd7 || busy1 !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold k=%0d got valid=%b data=%h s=%0d busy=%b want 1/3c/7/1",
                 k, valid1, data1, s1, busy1);
      end
    end
    ready1 = 1'b1;
    @(negedge clk);
    total++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0 || data1 !== 8'h3C) begin
      bad++;
      $display("FAIL bp_release got valid=%b busy=%b data=%h want 0/0/3c", valid1, busy1, data1);
    end
    repeat (3) @(negedge clk);
    total++;
    if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL bp_idle got valid=%b busy=%b want 0/0", valid1, busy1);
    end
  endtask

  task automatic test_continuous();
    int lat;
    int gap;
    in0 = 8'h81; ready0 = 1'b1; cont0 = 1'b1;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 3) start0 = 1'b1;
      if (n == 4) start0 = 1'b0;
      if (valid0) begin lat = n; break; end
    end
    total++;
    if (lat != 8 || data0 !== 8'h81) begin
      bad++;
      $display("FAIL cont_first got lat=%0d data=%h want 8/81", lat, data0);
    end
    in0 = 8'h7E;
    gap = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        total++;
        if (valid0 !== 1'b0 || busy0 !== 1'b1 || s0 !== 3'd0) begin
          bad++;
          $display("FAIL cont_restart got valid=%b busy=%b s=%0d want 0/1/0", valid0, busy0, s0);
        end
      end
      if (n == 4) start0 = 1'b1;
      if (n == 5) start0 = 1'b0;
      if (valid0) begin gap = n; break; end
    end
    total++;
    if (gap != 9 || data0 !== 8'h7E) begin
      bad++;
      $display("FAIL cont_second got gap=%0d data=%h want 9/7e", gap, data0);
    end
    cont0 = 1'b0;
    @(negedge clk);
    total++;
    if (valid0 !== 1'b0 || busy0 !== 1'b0 || data0 !== 8'h7E) begin
      bad++;
      $display("FAIL cont_stop got valid=%b busy=%b data=%h want 0/0/7e", valid0, busy0, data0);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    in1 = 8'hC3; ready1 = 1'b1; cont1 = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0; start1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start1 = 1'b0;
    total++;
    if (s1 !== 3'd0 || valid1 !== 1'b0 || busy1 !== 1'b0 || data1 !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset got s=%0d valid=%b busy=%b data=%h want 0/0/0/00",
               s1, valid1, busy1, data1);
    end
    @(negedge clk);
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_start got busy=%b want 0", busy1);
    end
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (valid1) begin lat = n; break; end
    end
    total++;
    if (lat != 16 || data1 !== 8'hC3) begin
      bad++;
      $display("FAIL mid_rescan got lat=%0d data=%h want 16/c3", lat, data1);
    end
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    start1 = 1'b0; cont1 = 1'b0; ready1 = 1'b0; in1 = 8'h00;
    start0 = 1'b0; cont0 = 1'b0; ready0 = 1'b0; in0 = 8'h00;
    test_reset();
    test_single_scan();
    test_walking();
    test_backpressure();
    test_continuous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
